// File: rtl/jpeg_raster_reorder.sv
// rtl/jpeg_raster_reorder.sv - MCU-ordered to raster-ordered pixel reorder buffer
// Two MCU-row banks ping-pong between an MCU-order writer and a raster-order reader.
module jpeg_raster_reorder #(
  parameter int MAX_WIDTH = 1024,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ai_we,
  output logic             ao_next,
  input  logic             ai_begin,
  input  logic             ai_end,
  input  logic [PIX_W-1:0] ai_r,
  input  logic [PIX_W-1:0] ai_g,
  input  logic [PIX_W-1:0] ai_b,
  input  logic             ci_411,
  input  logic [15:0]      ci_width,
  input  logic [15:0]      ci_heigth,
  output logic             bo_we,
  input  logic             bi_next,
  output logic [PIX_W-1:0] bo_r,
  output logic [PIX_W-1:0] bo_g,
  output logic [PIX_W-1:0] bo_b,
  output logic             bo_sof,
  output logic             bo_eol,
  output logic             bo_eof,
  output logic             co_err
);

  localparam int DW    = 3 * PIX_W;
  localparam int DEPTH = 32 * MAX_WIDTH;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_t;
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM} rd_state_t;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data;

  bank_t     bank_st [2];
  rd_state_t rd_state, rd_next;
  logic      wb, rb, err, frame_active;

  logic        cfg_m16;
  logic [15:0] cfg_w, cfg_h, cfg_mw, cfg_mh;
  logic [7:0]  w_p;
  logic [15:0] w_mi, w_mr;

  logic [15:0] rx, rd_y;
  logic [3:0]  ry;
  logic        s1_v, s1_sof, s1_eol, s1_eof;

  // Writer: position of the incoming pixel (a begin pixel always restarts at 0)
  logic        acc, take, abort;
  logic        c_m16;
  logic [15:0] c_w, c_mw, c_mh, calc_mw, calc_mh, mi, mr;
  logic [16:0] sum_w16, sum_w8, sum_h16, sum_h8;
  logic [7:0]  p;
  logic [3:0]  lrow, lcol;
  logic [19:0] x;
  logic        last_p, row_done, frame_done, end_bad, mem_we;
  logic [AW-1:0] wr_addr, rd_addr;

  assign acc   = ai_we & ao_next;
  assign take  = acc & (ai_begin | frame_active);
  assign abort = acc & ai_begin & frame_active;

  assign sum_w16 = {1'b0, ci_width} + 17'd15;
  assign sum_w8  = {1'b0, ci_width} + 17'd7;
  assign sum_h16 = {1'b0, ci_heigth} + 17'd15;
  assign sum_h8  = {1'b0, ci_heigth} + 17'd7;
  assign calc_mw = ci_411 ? {3'b0, sum_w16[16:4]} : {2'b0, sum_w8[16:3]};
  assign calc_mh = ci_411 ? {3'b0, sum_h16[16:4]} : {2'b0, sum_h8[16:3]};

  assign c_m16 = ai_begin ? ci_411   : cfg_m16;
  assign c_w   = ai_begin ? ci_width : cfg_w;
  assign c_mw  = ai_begin ? calc_mw  : cfg_mw;
  assign c_mh  = ai_begin ? calc_mh  : cfg_mh;
  assign p     = ai_begin ? 8'd0  : w_p;
  assign mi    = ai_begin ? 16'd0 : w_mi;
  assign mr    = ai_begin ? 16'd0 : w_mr;

  assign lrow = c_m16 ? p[7:4] : {1'b0, p[5:3]};
  assign lcol = c_m16 ? p[3:0] : {1'b0, p[2:0]};
  assign x    = c_m16 ? {mi, lcol} : {1'b0, mi, lcol[2:0]};

  assign last_p     = c_m16 ? (p == 8'd255) : (p == 8'd63);
  assign row_done   = last_p && (mi == c_mw - 16'd1);
  assign frame_done = row_done && (mr == c_mh - 16'd1);
  assign end_bad    = take && ai_end && !frame_done;
  // Padding pixels right of the image (or beyond the RAM width) are dropped
  assign mem_we     = take && (x < {4'b0, c_w}) && (x < 20'(MAX_WIDTH));
  assign wr_addr    = AW'(32'({wb, lrow}) * 32'(MAX_WIDTH) + 32'(x));

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_active <= 1'b0;
      wb           <= 1'b0;
      err          <= 1'b0;
      w_p          <= '0;
      w_mi         <= '0;
      w_mr         <= '0;
      cfg_m16      <= 1'b0;
      cfg_w        <= '0;
      cfg_h        <= '0;
      cfg_mw       <= '0;
      cfg_mh       <= '0;
    end else if (take) begin
      if (ai_begin) begin
        cfg_m16 <= ci_411;
        cfg_w   <= ci_width;
        cfg_h   <= ci_heigth;
        cfg_mw  <= calc_mw;
        cfg_mh  <= calc_mh;
      end
      if (frame_done || end_bad) begin
        frame_active <= 1'b0;
        w_p          <= '0;
        w_mi         <= '0;
        w_mr         <= '0;
      end else begin
        frame_active <= 1'b1;
        w_p          <= last_p ? 8'd0 : p + 8'd1;
        w_mi         <= last_p ? (row_done ? 16'd0 : mi + 16'd1) : mi;
        w_mr         <= row_done ? mr + 16'd1 : mr;
      end
      if (row_done || end_bad) wb <= ~wb;
      if (end_bad || abort || (ai_begin && (ci_width > 16'(MAX_WIDTH)))) err <= 1'b1;
    end
  end

  // Reader: a bank is released as soon as its last pixel has been read out of RAM
  logic [15:0] eff_w;
  logic        out_ready, issue, row_end, bank_last_row, is_eof, rel;

  assign eff_w         = (cfg_w > 16'(MAX_WIDTH)) ? 16'(MAX_WIDTH) : cfg_w;
  assign out_ready     = !bo_we || bi_next;
  assign issue         = ((rd_state == S_PRIME) || (rd_state == S_STREAM)) && (!s1_v || out_ready);
  assign row_end       = (rx == eff_w - 16'd1);
  assign bank_last_row = (cfg_m16 ? (ry == 4'd15) : (ry == 4'd7)) || (rd_y == cfg_h - 16'd1);
  assign is_eof        = row_end && (rd_y == cfg_h - 16'd1);
  assign rel           = issue && row_end && bank_last_row;
  assign rd_addr       = AW'(32'({rb, ry}) * 32'(MAX_WIDTH) + 32'(rx));

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      S_IDLE:   if (bank_st[rb] == B_FULL) rd_next = S_PRIME;
      S_PRIME:  if (issue) rd_next = rel ? ((bank_st[~rb] == B_FULL) ? S_PRIME : S_IDLE) : S_STREAM;
      S_STREAM: if (rel) rd_next = (bank_st[~rb] == B_FULL) ? S_PRIME : S_IDLE;
      default:  rd_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0] <= B_EMPTY;
      bank_st[1] <= B_EMPTY;
      rb         <= 1'b0;
    end else if (abort) begin
      bank_st[wb]  <= B_FILLING;
      bank_st[~wb] <= B_EMPTY;
      rb           <= wb;
    end else begin
      if (rel) begin
        bank_st[rb] <= B_EMPTY;
        rb          <= ~rb;
      end
      if (take) bank_st[wb] <= (row_done || end_bad) ? B_FULL : B_FILLING;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      rd_state <= S_IDLE;
      rx       <= '0;
      ry       <= '0;
      rd_y     <= '0;
      s1_v     <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
      bo_we    <= 1'b0;
      bo_r     <= '0;
      bo_g     <= '0;
      bo_b     <= '0;
      bo_sof   <= 1'b0;
      bo_eol   <= 1'b0;
      bo_eof   <= 1'b0;
    end else begin
      rd_state <= rd_next;
      if (issue) begin
        s1_v   <= 1'b1;
        s1_sof <= (rd_y == 16'd0) && (rx == 16'd0);
        s1_eol <= row_end;
        s1_eof <= is_eof;
        if (row_end) begin
          rx   <= '0;
          ry   <= bank_last_row ? 4'd0 : ry + 4'd1;
          rd_y <= is_eof ? 16'd0 : rd_y + 16'd1;
        end else begin
          rx <= rx + 16'd1;
        end
      end else if (out_ready) begin
        s1_v <= 1'b0;
      end
      if (out_ready) begin
        bo_we  <= s1_v;
        bo_r   <= s1_v ? rd_data[DW-1:2*PIX_W] : '0;
        bo_g   <= s1_v ? rd_data[2*PIX_W-1:PIX_W] : '0;
        bo_b   <= s1_v ? rd_data[PIX_W-1:0] : '0;
        bo_sof <= s1_v & s1_sof;
        bo_eol <= s1_v & s1_eol;
        bo_eof <= s1_v & s1_eof;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= {ai_r, ai_g, ai_b};
    if (issue) rd_data <= mem[rd_addr];
  end

  assign ao_next = !rst && (bank_st[wb] != B_FULL);
  assign co_err  = err && !rst;

endmodule

// File: doc/jpeg_raster_reorder.md
JPEG_RASTER_REORDER -- requirements
Module: jpeg_raster_reorder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameters SHALL be one per line, as listed in REQ-003 to REQ-004.
REQ-003 MAX_WIDTH, default 1024, SHALL set the maximum image width in pixels; the legal range is 16 to 4096.
REQ-004 PIX_W, default 8, SHALL set the width of each colour component.
REQ-005 Ports SHALL be, in this order (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ai_we  in  1  input pixel valid.
- ao_next  out  1  input ready; a pixel transfers when ai_we & ao_next.
- ai_begin  in  1  marks the first pixel of a frame.
- ai_end  in  1  marks the last pixel of a frame.
- ai_r / ai_g / ai_b  in  PIX_W each  MCU-ordered pixel.
- ci_411  in  1  1 = 16x16 MCU, 0 = 8x8 MCU.
- ci_width / ci_heigth  in  16 each  image size in pixels.
- bo_we  out  1  output valid.
- bi_next  in  1  output ready.
- bo_r / bo_g / bo_b  out  PIX_W each  raster-ordered pixel.
- bo_sof / bo_eol / bo_eof  out  1 each  first pixel of frame, last pixel of line, last pixel of frame.
- co_err  out  1  sticky framing error.

Function
REQ-006 The MCU edge M SHALL be 16 when ci_411 = 1 and 8 otherwise.
REQ-007 The MCU count per row SHALL be mcu_w = ceil(ci_width/M), and the MCU row count SHALL be mcu_h = ceil(ci_heigth/M).
REQ-008 The block SHALL sample ci_411, ci_width and ci_heigth only on an accepted pixel that has ai_begin = 1.
REQ-009 Input order SHALL be as follows, with input index n counting from 0 within an MCU row:
- MCU index = n / (M*M); pixel index p = n % (M*M).
- Local row = p / M; local column = p % M.
- x = MCU index * M + local column.
REQ-010 Storage SHALL be two banks, each M_max=16 rows by MAX_WIDTH pixels of 3*PIX_W bits, using synchronous-read RAM.
REQ-011 Accepted pixels with x >= ci_width SHALL be discarded and not written.
REQ-012 Bank state SHALL be EMPTY, FILLING or FULL for each bank.
REQ-013 The writer SHALL fill bank wb, and the reader SHALL drain bank rb.
REQ-014 When the last pixel of an MCU row is accepted (mcu_w*M*M pixels), bank wb SHALL become FULL and wb SHALL toggle.
REQ-015 ao_next SHALL equal "bank wb is not FULL" and not rst.
REQ-016 When bank rb is FULL, the reader SHALL emit rows 0..M-1 with x = 0..ci_width-1 for each row.
REQ-017 The reader SHALL skip rows whose global y >= ci_heigth (bottom cropping).
REQ-018 After the last emitted pixel of a bank, that bank SHALL become EMPTY and rb SHALL toggle.
REQ-019 The reader FSM SHALL have states IDLE, PRIME and STREAM, with these transitions:
- IDLE -> PRIME when bank rb is FULL.
- PRIME is a one-cycle RAM read; PRIME -> STREAM.
- STREAM -> IDLE after the bank's last pixel transfers.
REQ-020 bo_* outputs SHALL be registered.
REQ-021 While bo_we & !bi_next, all bo_* outputs SHALL hold stable.
REQ-022 While the reader streams and bi_next = 1, it SHALL output one pixel per clock, with no bubble between rows or between banks that are already FULL.
REQ-023 Marker outputs SHALL behave as follows:
- bo_sof = 1 on frame pixel (0,0).
- bo_eol = 1 on x = ci_width-1.
- bo_eof = 1 on (ci_width-1, ci_heigth-1).
REQ-024 Write and read of different banks in the same cycle SHALL both proceed.
REQ-025 A bank SHALL never be written while FULL or while being drained.
REQ-026 An accepted ai_end SHALL be checked against the expected last input pixel (index mcu_w*mcu_h*M*M-1).
REQ-027 On an ai_end mismatch, co_err SHALL be set to 1 and remain 1 until reset, and the current bank SHALL be forced FULL.
REQ-028 An accepted ai_begin during a frame in progress SHALL abort that frame:
- Both banks become EMPTY.
- The reader returns to IDLE and bo_we drops.
- The pixel is taken as pixel 0 of the new frame.
- co_err is set to 1.
REQ-029 Counter widths SHALL accommodate ci_width and ci_heigth up to 65535; when ci_width > MAX_WIDTH, co_err SHALL be set to 1 and x >= MAX_WIDTH SHALL be discarded.

Reset
REQ-030 While rst = 1, the block SHALL drive ao_next = 0, bo_we = 0, bo_sof = bo_eol = bo_eof = 0, bo_r/g/b = 0 and co_err = 0.
REQ-031 On reset, both banks SHALL become EMPTY, wb = rb = 0, the FSM SHALL enter IDLE, and all counters SHALL clear.
REQ-032 Reset asserted mid-frame SHALL discard all buffered pixels, and no partial output SHALL appear after reset deasserts.
REQ-033 ao_next SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-034 Scenario 1: 40x40, ci_411 = 1, 2304 input pixels, bi_next = 1 -> 1600 output pixels in raster order, 40 bo_eol pulses, one bo_sof, bo_eof on the 1600th pixel, co_err = 0.
REQ-035 Scenario 2: 24x8, ci_411 = 0, pixel value = input index -> output row 0 = indices 0..7, 64..71, 128..135 in that order.
REQ-036 Scenario 3: 40x40, ci_411 = 1, with bi_next driven by a random pattern of 30% low -> the same 1600-pixel stream as Scenario 1, and bo_* stable during every stall.
REQ-037 Scenario 4: ci_width = MAX_WIDTH, bi_next held low -> ao_next falls after exactly 2 MCU rows are accepted, and resumes after the first bank drains.
REQ-038 Scenario 5: rst pulsed after 1000 input pixels, followed by a new 16x16 frame -> output is only the 256 new pixels, with bo_sof on the first.
REQ-039 Scenario 6: ai_end asserted on input pixel 100 of a 40x40 frame -> co_err = 1 and stays 1 until the next rst.
